// File: rtl/ha_array_reducer.sv
// ha_array_reducer: reduces four ha_array partial-product row pairs (b, t)
// into a 16-bit product by sequential shift-accumulate.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   row-set handshake (capture in IDLE only)
//   ha_array_<r>_b/_t    row r carry-save (7b) and sum (9b) bits, r = 0..3
//   out_valid, out_ready result handshake (held in DONE until accepted)
//   p, ovf               product modulo 2^16, bit 16 of the accumulated sum
module ha_array_reducer #(
   parameter int ROWS_PER_CYCLE = 1,
   parameter bit OUT_REG        = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  ha_array_0_b,
   input  logic [8:0]  ha_array_0_t,
   input  logic [6:0]  ha_array_1_b,
   input  logic [8:0]  ha_array_1_t,
   input  logic [6:0]  ha_array_2_b,
   input  logic [8:0]  ha_array_2_t,
   input  logic [6:0]  ha_array_3_b,
   input  logic [8:0]  ha_array_3_t,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] p,
   output logic        ovf
);

   if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 2 && ROWS_PER_CYCLE != 4) begin : g_bad_rpc
      $error("ha_array_reducer: ROWS_PER_CYCLE must be 1, 2 or 4");
   end

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      DONE
   } state_t;

   // k advances modulo 4; the step wraps to 0 for ROWS_PER_CYCLE=4, which is
   // harmless because that single add is also the last one.
   localparam logic [1:0] STEP   = 2'(ROWS_PER_CYCLE);
   localparam logic [1:0] LAST_K = 2'(4 - ROWS_PER_CYCLE);

   state_t      state;
   logic [63:0] rows_q;
   logic [16:0] acc;
   logic [1:0]  k;
   logic [15:0] p_q;
   logic        ovf_q;
   logic [9:0]  row_val [4];
   logic [16:0] acc_nxt;
   logic [1:0]  idx;

   // Row r occupies rows_q[16r +: 16] as {b, t}; R_r = t + (b << 2).
   always_comb begin
      for (int r = 0; r < 4; r++) begin
         row_val[r] = {1'b0, rows_q[r*16 +: 9]} + {1'b0, rows_q[r*16+9 +: 7], 2'b00};
      end
   end

   // Add rows k .. k+ROWS_PER_CYCLE-1, each shifted by 2r.
   always_comb begin
      acc_nxt = acc;
      idx     = '0;
      for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
         idx     = k + 2'(j);
         acc_nxt = acc_nxt + ({7'd0, row_val[idx]} << {idx, 1'b0});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         rows_q    <= '0;
         acc       <= '0;
         k         <= '0;
         p_q       <= '0;
         ovf_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  rows_q   <= {ha_array_3_b, ha_array_3_t,
                               ha_array_2_b, ha_array_2_t,
                               ha_array_1_b, ha_array_1_t,
                               ha_array_0_b, ha_array_0_t};
                  acc      <= '0;
                  k        <= '0;
                  in_ready <= 1'b0;
                  state    <= ACC;
               end
            end
            ACC: begin
               acc <= acc_nxt;
               k   <= k + STEP;
               if (k == LAST_K) begin
                  p_q       <= acc_nxt[15:0];
                  ovf_q     <= acc_nxt[16];
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   if (OUT_REG) begin : g_out_reg
      assign p   = p_q;
      assign ovf = ovf_q;
   end else begin : g_out_comb
      assign p   = acc[15:0];
      assign ovf = acc[16];
   end

endmodule

// File: tb/tb_ha_array_reducer.sv
// Testbench for ha_array_reducer: directed vectors plus a random run
// against a bit-weight model, on three parameterisations.
module tb_ha_array_reducer;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [63:0]      d   = '0;
   logic [2:0]       iv  = '0;
   logic [2:0]       ordy = '0;
   logic [2:0]       rdy;
   logic [2:0]       ov;
   logic [2:0]       of;
   logic [2:0][15:0] pv;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_cap = 0;
   int prev_cap = 0;
   int cap_cnt  = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (iv[0] && rdy[0]) begin
         prev_cap = last_cap;
         last_cap = cyc;
         cap_cnt++;
      end
      if (ov[0] && ordy[0]) done_cnt++;
   end

   ha_array_reducer #(.ROWS_PER_CYCLE(1), .OUT_REG(1'b1)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]),
      .ha_array_0_b(d[15:9]),  .ha_array_0_t(d[8:0]),
      .ha_array_1_b(d[31:25]), .ha_array_1_t(d[24:16]),
      .ha_array_2_b(d[47:41]), .ha_array_2_t(d[40:32]),
      .ha_array_3_b(d[63:57]), .ha_array_3_t(d[56:48]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .p(pv[0]), .ovf(of[0])
   );

   ha_array_reducer #(.ROWS_PER_CYCLE(2), .OUT_REG(1'b0)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]),
      .ha_array_0_b(d[15:9]),  .ha_array_0_t(d[8:0]),
      .ha_array_1_b(d[31:25]), .ha_array_1_t(d[24:16]),
      .ha_array_2_b(d[47:41]), .ha_array_2_t(d[40:32]),
      .ha_array_3_b(d[63:57]), .ha_array_3_t(d[56:48]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .p(pv[1]), .ovf(of[1])
   );

   ha_array_reducer #(.ROWS_PER_CYCLE(4), .OUT_REG(1'b1)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]),
      .ha_array_0_b(d[15:9]),  .ha_array_0_t(d[8:0]),
      .ha_array_1_b(d[31:25]), .ha_array_1_t(d[24:16]),
      .ha_array_2_b(d[47:41]), .ha_array_2_t(d[40:32]),
      .ha_array_3_b(d[63:57]), .ha_array_3_t(d[56:48]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .p(pv[2]), .ovf(of[2])
   );

   // Sum of individual bit weights: t[i] -> 2^(2r+i), b[i] -> 2^(2r+i+2).
   function automatic logic [16:0] model(input logic [63:0] v);
      int s;
      s = 0;
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 9; i++)
            if (v[r*16+i]) s += (1 << (2*r + i));
         for (int i = 0; i < 7; i++)
            if (v[r*16+9+i]) s += (1 << (2*r + i + 2));
      end
      return 17'(s);
   endfunction

   // Called #1 after an edge. Returns edges from capture to out_valid.
   task automatic send(input int u, input logic [63:0] v, input int stall,
                       output int lat, output logic [15:0] pp, output logic oo);
      int n;
      n = 0;
      d = v;
      iv[u] = 1'b1;
      while (!rdy[u] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      iv[u] = 1'b0;
      lat = 0;
      while (!ov[u] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      pp = pv[u];
      oo = of[u];
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
      end
      ordy[u] = 1'b1;
      @(posedge clk); #1;
      ordy[u] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (rdy !== 3'b111) begin
         failures++;
         $display("FAIL reset_in_ready got=%b exp=111", rdy);
      end
      checks++;
      if (ov !== 3'b000) begin
         failures++;
         $display("FAIL reset_out_valid got=%b exp=000", ov);
      end
      checks++;
      if (pv[0] !== 16'h0 || of[0] !== 1'b0) begin
         failures++;
         $display("FAIL reset_p got=%h/%b exp=0000/0", pv[0], of[0]);
      end
      checks++;
      if (pv[1] !== 16'h0 || of[1] !== 1'b0) begin
         failures++;
         $display("FAIL reset_acc got=%h/%b exp=0000/0", pv[1], of[1]);
      end
   endtask

   task automatic test_zero();
      int lat;
      logic [15:0] pp;
      logic oo;
      send(0, 64'h0, 0, lat, pp, oo);
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL zero_latency got=%0d exp=4", lat);
      end
      checks++;
      if (pp !== 16'h0 || oo !== 1'b0) begin
         failures++;
         $display("FAIL zero_p got=%h/%b exp=0000/0", pp, oo);
      end
      checks++;
      if (rdy[0] !== 1'b1 || ov[0] !== 1'b0) begin
         failures++;
         $display("FAIL zero_idle got=rdy%b ov%b exp=rdy1 ov0", rdy[0], ov[0]);
      end
   endtask

   task automatic test_single_bits();
      logic [63:0] vec [4];
      logic [15:0] exp_p [4];
      int lat;
      logic [15:0] pp;
      logic oo;
      vec[0] = 64'h0000_0000_0000_0001; exp_p[0] = 16'd1;
      vec[1] = 64'h8000_0000_0000_0000; exp_p[1] = 16'd16384;
      vec[2] = 64'h0000_0000_0100_0000; exp_p[2] = 16'd1024;
      vec[3] = 64'h0000_0000_0000_FFFF; exp_p[3] = 16'd1019;
      for (int i = 0; i < 4; i++) begin
         send(0, vec[i], 0, lat, pp, oo);
         checks++;
         if (pp !== exp_p[i] || oo !== 1'b0 || lat !== 4) begin
            failures++;
            $display("FAIL single_bit%0d got=%0d/%b lat%0d exp=%0d/0 lat4",
                     i, pp, oo, lat, exp_p[i]);
         end
      end
   endtask

   task automatic test_all_ones();
      int lat;
      logic [15:0] pp;
      logic oo;
      send(0, '1, 0, lat, pp, oo);
      checks++;
      if (pp !== 16'h5257 || oo !== 1'b1) begin
         failures++;
         $display("FAIL all_ones_p got=%h/%b exp=5257/1", pp, oo);
      end
      checks++;
      if (lat !== 4) begin
         failures++;
         $display("FAIL all_ones_latency got=%0d exp=4", lat);
      end
   endtask

   task automatic test_rows_per_cycle();
      int lat;
      logic [15:0] pp;
      logic oo;
      send(1, '1, 0, lat, pp, oo);
      checks++;
      if (pp !== 16'h5257 || oo !== 1'b1 || lat !== 2) begin
         failures++;
         $display("FAIL rpc2 got=%h/%b lat%0d exp=5257/1 lat2", pp, oo, lat);
      end
      send(2, '1, 0, lat, pp, oo);
      checks++;
      if (pp !== 16'h5257 || oo !== 1'b1 || lat !== 1) begin
         failures++;
         $display("FAIL rpc4 got=%h/%b lat%0d exp=5257/1 lat1", pp, oo, lat);
      end
      send(2, 64'h8000_0000_0000_0000, 0, lat, pp, oo);
      checks++;
      if (pp !== 16'd16384 || oo !== 1'b0) begin
         failures++;
         $display("FAIL rpc4_row3 got=%0d/%b exp=16384/0", pp, oo);
      end
   endtask

   task automatic test_stall();
      int n;
      int done0;
      logic bad;
      done0 = done_cnt;
      d = '1;
      iv[0] = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (!ov[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (ov[0] !== 1'b1) begin
         failures++;
         $display("FAIL stall_reach_done got=%b exp=1", ov[0]);
      end
      for (int i = 0; i < 10; i++) begin
         d = {$urandom, $urandom};
         @(posedge clk); #1;
         bad = (pv[0] !== 16'h5257) || (of[0] !== 1'b1) ||
               (rdy[0] !== 1'b0) || (ov[0] !== 1'b1);
         checks++;
         if (bad) begin
            failures++;
            $display("FAIL stall_hold%0d got=p%h ovf%b rdy%b ov%b exp=p5257 ovf1 rdy0 ov1",
                     i, pv[0], of[0], rdy[0], ov[0]);
         end
      end
      d = 64'h0000_0008_0000_0000;
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      checks++;
      if (ov[0] !== 1'b0 || rdy[0] !== 1'b1) begin
         failures++;
         $display("FAIL stall_release got=ov%b rdy%b exp=ov0 rdy1", ov[0], rdy[0]);
      end
      @(posedge clk); #1;
      iv[0] = 1'b0;
      checks++;
      if (rdy[0] !== 1'b0) begin
         failures++;
         $display("FAIL stall_pending_accept got=rdy%b exp=rdy0", rdy[0]);
      end
      n = 0;
      while (!ov[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (pv[0] !== 16'd128 || n !== 4) begin
         failures++;
         $display("FAIL stall_pending_p got=%0d lat%0d exp=128 lat4", pv[0], n);
      end
      ordy[0] = 1'b1;
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      checks++;
      if (done_cnt - done0 !== 2) begin
         failures++;
         $display("FAIL stall_handshakes got=%0d exp=2", done_cnt - done0);
      end
   endtask

   task automatic test_reset_mid_acc();
      int lat;
      logic [15:0] pp;
      logic oo;
      logic seen;
      d = '1;
      iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (rdy[0] !== 1'b1 || ov[0] !== 1'b0 || pv[0] !== 16'h0 || of[0] !== 1'b0) begin
         failures++;
         $display("FAIL midacc_reset got=rdy%b ov%b p%h ovf%b exp=rdy1 ov0 p0000 ovf0",
                  rdy[0], ov[0], pv[0], of[0]);
      end
      checks++;
      if (pv[1] !== 16'h0 || of[1] !== 1'b0) begin
         failures++;
         $display("FAIL midacc_acc got=%h/%b exp=0000/0", pv[1], of[1]);
      end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (ov[0]) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL midacc_no_valid got=%b exp=0", seen);
      end
      send(0, 64'h0000_0008_0000_0000, 0, lat, pp, oo);
      checks++;
      if (pp !== 16'd128 || oo !== 1'b0 || lat !== 4) begin
         failures++;
         $display("FAIL midacc_next got=%0d/%b lat%0d exp=128/0 lat4", pp, oo, lat);
      end
   endtask

   task automatic test_back_to_back();
      int cap0;
      int done0;
      int n;
      cap0 = cap_cnt;
      done0 = done_cnt;
      d = 64'h0000_0000_0000_0001;
      ordy[0] = 1'b1;
      iv[0] = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      iv[0] = 1'b0;
      n = 0;
      while (!rdy[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      ordy[0] = 1'b0;
      checks++;
      if (last_cap - prev_cap !== 6) begin
         failures++;
         $display("FAIL b2b_interval got=%0d exp=6", last_cap - prev_cap);
      end
      checks++;
      if ((cap_cnt - cap0) !== (done_cnt - done0) || (cap_cnt - cap0) < 3) begin
         failures++;
         $display("FAIL b2b_count got=cap%0d done%0d exp=equal and >=3",
                  cap_cnt - cap0, done_cnt - done0);
      end
   endtask

   task automatic test_random();
      int lat;
      int done0;
      logic [15:0] pp;
      logic oo;
      logic [63:0] v;
      logic [16:0] exp_v;
      done0 = done_cnt;
      for (int i = 0; i < 100; i++) begin
         v = {$urandom, $urandom};
         exp_v = model(v);
         send(0, v, int'($urandom_range(0, 3)), lat, pp, oo);
         checks++;
         if (pp !== exp_v[15:0] || oo !== exp_v[16] || lat !== 4) begin
            failures++;
            $display("FAIL random%0d got=%h/%b lat%0d exp=%h/%b lat4",
                     i, pp, oo, lat, exp_v[15:0], exp_v[16]);
         end
      end
      checks++;
      if (done_cnt - done0 !== 100) begin
         failures++;
         $display("FAIL random_count got=%0d exp=100", done_cnt - done0);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_single_bits();
      test_all_ones();
      test_rows_per_cycle();
      test_stall();
      test_reset_mid_acc();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
